// File: rtl/key_schedule_expand.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule_expand
// Brief    : AES-128 key expansion (Nk=4, Nr=10) writing the 44x4 byte `word`
//            round-key memory read by AddRoundKey. Optional macro
//            KEYEXP_CYCLE_CNT_EN adds the 9-bit ap_cycles run-length counter.
// Revision : 1.0 - initial release
// ============================================================================
module key_schedule_expand #(
  parameter int NCOL       = 44,
  parameter int ROW_STRIDE = 120
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [4:0]  key_address0,
  output logic        key_ce0,
  input  logic [31:0] key_q0,
  output logic [7:0]  Sbox_address0,
  output logic        Sbox_ce0,
  input  logic [31:0] Sbox_q0,
  output logic [8:0]  word_address0,
  output logic        word_ce0,
  output logic        word_we0,
  output logic [31:0] word_d0,
  output logic [8:0]  word_address1,
  output logic        word_ce1,
  output logic        word_we1,
  output logic [31:0] word_d1
`ifdef KEYEXP_CYCLE_CNT_EN
  ,
  output logic [8:0]  ap_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SUB   = 3'd2,
    S_WR0   = 3'd3,
    S_WR1   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [8:0] c_ROW1    = 9'(ROW_STRIDE);
  localparam logic [8:0] c_ROW2    = 9'(2 * ROW_STRIDE);
  localparam logic [8:0] c_ROW3    = 9'(3 * ROW_STRIDE);
  localparam logic [5:0] c_LASTCOL = 6'(NCOL - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [5:0]        r_col;
  logic [2:0]        r_phase;
  logic [7:0]        r_rcon;
  // r_win[3] is the newest column (col-1), r_win[0] the oldest (col-4)
  logic [3:0][3:0][7:0] r_win;
  logic [3:0][7:0]   r_temp;

  logic              w_col_ge4;
  logic              w_col_sub;
  logic [3:0][7:0]   w_temp;
  logic [3:0][7:0]   w_v;
  logic [5:0]        w_col_inc;
  logic [1:0]        w_rot_idx;
  logic [1:0]        w_cap_idx;
  logic [8:0]        w_col_ext;
  logic              w_unused;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry state for a column: key fetch, S-box substitution or direct write
  function automatic state_t col_entry(input logic [5:0] c);
    if (c < 6'd4)
      return S_FETCH;
    else if (c[1:0] == 2'b00)
      return S_SUB;
    else
      return S_WR0;
  endfunction

  assign w_col_ge4 = (r_col >= 6'd4);
  assign w_col_sub = w_col_ge4 && (r_col[1:0] == 2'b00);
  assign w_temp    = (w_col_ge4 && !w_col_sub) ? r_win[3] : r_temp;
  assign w_v       = w_col_ge4 ? (r_win[0] ^ w_temp) : w_temp;
  assign w_col_inc = r_col + 6'd1;
  assign w_rot_idx = r_phase[1:0] + 2'd1;
  assign w_cap_idx = r_phase[1:0] - 2'd1;
  assign w_col_ext = {3'b000, r_col};
  assign w_unused  = ^{key_q0[31:8], Sbox_q0[31:8]};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_col   <= 6'd0;
      r_phase <= 3'd0;
      r_rcon  <= 8'h01;
      r_win   <= '0;
      r_temp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          r_phase <= 3'd0;
        end
        S_FETCH: begin
          // Byte requested in phase p arrives in phase p+1
          if (r_phase != 3'd0)
            r_temp[w_cap_idx] <= key_q0[7:0];
          r_phase <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
        end
        S_SUB: begin
          if (r_phase != 3'd0)
            r_temp[w_cap_idx] <= Sbox_q0[7:0];
          if (r_phase == 3'd4)
            r_temp[0] <= r_temp[0] ^ r_rcon;
          r_phase <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
        end
        S_WR1: begin
          r_win <= {w_v, r_win[3:1]};
          r_col <= w_col_inc;
          if (w_col_sub)
            r_rcon <= xtime(r_rcon);
        end
        S_DONE: begin
          r_col  <= 6'd0;
          r_rcon <= 8'h01;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    ap_done       = 1'b0;
    ap_ready      = 1'b0;
    ap_idle       = 1'b0;
    key_address0  = 5'd0;
    key_ce0       = 1'b0;
    Sbox_address0 = 8'd0;
    Sbox_ce0      = 1'b0;
    word_address0 = 9'd0;
    word_ce0      = 1'b0;
    word_we0      = 1'b0;
    word_d0       = 32'd0;
    word_address1 = 9'd0;
    word_ce1      = 1'b0;
    word_we1      = 1'b0;
    word_d1       = 32'd0;
    case (r_state)
      S_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start)
          w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (r_phase != 3'd4) begin
          key_ce0      = 1'b1;
          key_address0 = {1'b0, r_col[1:0], r_phase[1:0]};
        end else begin
          w_state_nxt = S_WR0;
        end
      end
      S_SUB: begin
        if (r_phase != 3'd4) begin
          Sbox_ce0      = 1'b1;
          Sbox_address0 = r_win[3][w_rot_idx];
        end else begin
          w_state_nxt = S_WR0;
        end
      end
      S_WR0: begin
        word_ce0      = 1'b1;
        word_we0      = 1'b1;
        word_address0 = w_col_ext;
        word_d0       = {24'd0, w_v[0]};
        word_ce1      = 1'b1;
        word_we1      = 1'b1;
        word_address1 = c_ROW1 + w_col_ext;
        word_d1       = {24'd0, w_v[1]};
        w_state_nxt   = S_WR1;
      end
      S_WR1: begin
        word_ce0      = 1'b1;
        word_we0      = 1'b1;
        word_address0 = c_ROW2 + w_col_ext;
        word_d0       = {24'd0, w_v[2]};
        word_ce1      = 1'b1;
        word_we1      = 1'b1;
        word_address1 = c_ROW3 + w_col_ext;
        word_d1       = {24'd0, w_v[3]};
        w_state_nxt   = (r_col == c_LASTCOL) ? S_DONE : col_entry(w_col_inc);
      end
      S_DONE: begin
        ap_done     = 1'b1;
        ap_ready    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef KEYEXP_CYCLE_CNT_EN
  logic [8:0] r_cycles;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      r_cycles <= 9'd0;
    else if (r_state == S_IDLE) begin
      if (ap_start)
        r_cycles <= 9'd0;
    end else
      r_cycles <= r_cycles + 9'd1;
  end

  assign ap_cycles = r_cycles;
`endif

endmodule
`default_nettype wire

// File: doc/key_schedule_expand.md
Name: key_schedule_expand

Overview:
- Writer for the `word` round-key memory that AddRoundKey reads.
- Expands a 128-bit AES key (Nk=4, Nr=10) into 44 columns × 4 rows of bytes.
- Writes byte word[i][j] to address i*120 + j. Rows 0..3 use base offsets 0, 120, 240 and 360, matching AddRoundKey's read addressing.
- Uses the same ap_start/ap_done/ap_idle/ap_ready block-level handshake and single-cycle-latency memory ports as AddRoundKey.

Parameters:
- NCOL, 44: total key columns; the run ends after column NCOL-1.
- ROW_STRIDE, 120: address offset between rows of `word`.

Ports:
- ap_clk  in  1  clock; all state on the rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  start request, sampled in S_IDLE.
- ap_done  out  1  one-cycle pulse in S_DONE.
- ap_idle  out  1  high in S_IDLE while ap_start=0.
- ap_ready  out  1  one-cycle pulse in S_DONE (same cycle as ap_done).
- key_address0  out  5  key byte index 0..15.
- key_ce0  out  1  key read enable.
- key_q0  in  32  key byte on bits [7:0]; valid the cycle after ce.
- Sbox_address0  out  8  S-box lookup index.
- Sbox_ce0  out  1  S-box read enable.
- Sbox_q0  in  32  S-box result on bits [7:0]; 1-cycle latency.
- word_address0  out  9  write address, rows 0/2.
- word_ce0  out  1  port 0 enable.
- word_we0  out  1  port 0 write enable.
- word_d0  out  32  write data, zero-extended byte.
- word_address1  out  9  write address, rows 1/3.
- word_ce1  out  1  port 1 enable.
- word_we1  out  1  port 1 write enable.
- word_d1  out  32  write data, zero-extended byte.

Behaviour:
- Reset: asynchronous, active-high.
  - Forces S_IDLE, col=0, rcon=0x01, and clears the 16-byte window.
  - All ce/we, ap_done and ap_ready are 0; ap_idle follows ap_start.
  - Reset mid-run aborts immediately; no further writes occur.
- State: col counter (6b); window of the last 4 columns (4×4 bytes); temp[0..3]; rcon (8b).
- FSM:
  - S_IDLE: ap_start=1 → S_FETCH. ap_start is ignored in all other states.
  - S_FETCH, used when col<4: 5 cycles.
    - Cycles 0..3 issue key_address0 = col*4+i with key_ce0=1.
    - Each byte is captured the following cycle into temp[i] = key_q0[7:0].
    - Then → S_WR0.
  - S_SUB, used when col≥4 and col%4==0: 5 cycles.
    - Cycles 0..3 issue Sbox_address0 = window[col-1][(i+1)%4].
    - The captured result goes to temp[i].
    - On the last capture: temp[0] ^= rcon.
    - Then → S_WR0.
  - Otherwise (col≥4, col%4≠0): temp[i] = window[col-1][i], computed combinationally; go directly to S_WR0.
  - For col≥4: value v[i] = window[col-4][i] ^ temp[i]. For col<4: v[i] = temp[i].
  - S_WR0: port0 writes v[0] at address col; port1 writes v[1] at address 120+col. Both ce=we=1. → S_WR1.
  - S_WR1:
    - Port0 writes v[2] at 240+col; port1 writes v[3] at 360+col.
    - Shift v into the window.
    - If a S_SUB was done this column, rcon = xtime(rcon) (0x80 → 0x1b).
    - col++. If col==NCOL-1 → S_DONE, else → S_FETCH/S_SUB/S_WR0 per the rules above for the next column.
  - S_DONE: ap_done=ap_ready=1 for one cycle → S_IDLE. col and rcon reset to 0 and 0x01.
- Latency:
  - Per column: 7 cycles for FETCH/SUB columns, 2 cycles for plain columns.
  - Total 4×7 + 10×7 + 30×2 = 158 cycles after the S_IDLE start cycle.
  - ap_done is high in cycle 160, counting the start-accept cycle as 1.
- Widths: addresses are zero-extended. Address sums never exceed 403 (fits in 9 bits). Write data bits [31:8] are always 0.
- No write ever targets the same address on both ports in one cycle.

Optional Feature:
- KEYEXP_CYCLE_CNT_EN defined:
  - Adds output `ap_cycles`, 9 bits.
  - Cleared on the start-accept cycle; increments every non-idle cycle; holds its value in S_IDLE.
  - Expected value after a run: 159. Reset value 0.
- Undefined: no port and no counter logic.

Test Plan:
- Reset then idle: ap_rst=1 → all ce/we=0, ap_done=0. With ap_start=0 after reset → ap_idle=1.
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c (bytes at key[0..15] in that order):
  - Writes addr0=0x2b, addr120=0x7e, addr4=0xa0, addr124=0xfa.
  - Final column: addr43=0xb6, addr403=0xa6.
- Same run → exactly 176 writes, each address in {0..43, 120..163, 240..283, 360..403} written once. ap_done and ap_ready each pulse exactly once, in cycle 160.
- Holding ap_start=1 for the whole run → key_ce0 active for 16 cycles only until ap_done. A second run starts only from S_IDLE and reproduces identical data (rcon restarts at 0x01).
- Assert ap_rst during col=20 → outputs idle within the same cycle. A restart yields the full, correct 176-write sequence.
- KEYEXP_CYCLE_CNT_EN defined → ap_cycles=159 after the FIPS run; reads 0 after reset.
